// File: rtl/mux_arb2.sv
// Two-port round-robin arbiter with registered output mux.
// Define ARB_BURST_LIMIT_EN to cap each ownership at MAX_BURST transfers while the other port waits.
module mux_arb2 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s0,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_reg, state_next;
  logic             ptr_reg, ptr_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_reg;
  logic             xfer;
  logic             burst_done;

  generate
    if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("mux_arb2: MAX_BURST must be at least 1");
    end
  endgenerate

  assign gnt0      = (state_reg == OWN0);
  assign gnt1      = (state_reg == OWN1);
  assign s0        = (state_reg == OWN1);
  assign busy      = gnt0 | gnt1;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign xfer      = (gnt0 & req0) | (gnt1 & req1);

`ifdef ARB_BURST_LIMIT_EN
  localparam int             CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  assign burst_done = (cnt_reg == CNT_MAX);

  // Clear on entering an owner state, then count transfers up to the cap.
  always_comb begin
    cnt_next = cnt_reg;
    if ((state_next != state_reg) && (state_next != IDLE)) begin
      cnt_next = '0;
    end else if (xfer && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign burst_done = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (req0 && req1) begin
          state_next = ptr_reg ? OWN1 : OWN0;
        end else if (req0) begin
          state_next = OWN0;
        end else if (req1) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        // Hand over directly when the owner drops or its burst is used up.
        if (req0 && !(burst_done && req1)) begin
          state_next = OWN0;
        end else if (req1) begin
          state_next = OWN1;
        end else begin
          state_next = IDLE;
        end
      end
      OWN1: begin
        if (req1 && !(burst_done && req0)) begin
          state_next = OWN1;
        end else if (req0) begin
          state_next = OWN0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if ((state_reg == OWN0) && (state_next != OWN0)) begin
      ptr_next = 1'b1;
    end else if ((state_reg == OWN1) && (state_next != OWN1)) begin
      ptr_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      out_valid_reg <= xfer;
      if (xfer) begin
        out_reg <= s0 ? in1 : in0;
      end
    end
  end

endmodule
